pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register for the processor's inter-stage boundaries (IF/ID onward). It carries PC plus one instruction/data word with valid/ready handshaking. A 2-entry skid buffer gives full throughput under back-pressure. It keeps the existing freeze and flush semantics and adds a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_stage_reg_pkg.sv | 21 ++
 rtl/pipe_entry_reg.sv | 30 +++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: default path widths, the bubble instruction and
// the entry record carried by every inter-stage register.
package pipe_stage_reg_pkg;

    localparam int unsigned PcW   = 32;
    localparam int unsigned DataW = 32;
    localparam logic [DataW-1:0] NopInstr = 32'h0000_0000;

    typedef struct packed {
        logic             valid;
        logic [PcW-1:0]   pc;
        logic [DataW-1:0] ins;
    } entry_t;

    // A cycle is stalled when a held entry cannot leave, or the stage is frozen.
    function automatic logic stall_cycle(input logic m_v, input logic out_ready,
                                         input logic freeze);
        return (m_v & ~out_ready) | freeze;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+payload slot of the elastic stage; load sets valid, clear empties
// the slot and zeroes the payload.
module pipe_entry_reg #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [PC_W-1:0]   pc_d,
    input  logic [DATA_W-1:0] ins_d,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] ins
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= 1'b0;
            pc    <= '0;
            ins   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_d;
            ins   <= ins_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, freeze/flush control
// and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = DataW,
    parameter int unsigned       PC_W      = PcW,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NopInstr),
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   PC_in,
    input  logic [DATA_W-1:0] Instruction_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   PC,
    output logic [DATA_W-1:0] Instruction,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_v, s_v;
    logic [PC_W-1:0]   m_pc, s_pc, m_pc_d;
    logic [DATA_W-1:0] m_ins, s_ins, m_ins_d;
    logic              accept, consume;
    logic              m_load, m_clr, m_from_skid, s_load, s_clr;
    logic [CNT_W-1:0]  cnt_q;

    assign in_ready = ~s_v & ~freeze & ~rst;
    assign accept   = in_valid & in_ready;
    assign consume  = m_v & out_ready & ~freeze;

    // Freeze already forces accept and consume low, so entries hold by default.
    always_comb begin
        m_load      = 1'b0;
        m_from_skid = 1'b0;
        m_clr       = flush;
        s_load      = 1'b0;
        s_clr       = flush;
        if (!flush) begin
            if (consume) begin
                if (s_v) begin
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                    s_clr       = 1'b1;
                end else if (accept) begin
                    m_load = 1'b1;
                end else begin
                    m_clr = 1'b1;
                end
            end else if (accept) begin
                if (m_v) begin
                    s_load = 1'b1;
                end else begin
                    m_load = 1'b1;
                end
            end
        end
    end

    assign m_pc_d  = m_from_skid ? s_pc  : PC_in;
    assign m_ins_d = m_from_skid ? s_ins : Instruction_in;

    pipe_entry_reg #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .clr   (m_clr),
        .load  (m_load),
        .pc_d  (m_pc_d),
        .ins_d (m_ins_d),
        .valid (m_v),
        .pc    (m_pc),
        .ins   (m_ins)
    );

    pipe_entry_reg #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (s_clr),
        .load  (s_load),
        .pc_d  (PC_in),
        .ins_d (Instruction_in),
        .valid (s_v),
        .pc    (s_pc),
        .ins   (s_ins)
    );

    // Counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall_cycle(m_v, out_ready, freeze) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid   = m_v;
    assign PC          = m_v ? m_pc  : '0;
    assign Instruction = m_v ? m_ins : NOP_INSTR;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random stimulus for pipe_stage_reg against a FIFO-of-entries model.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int unsigned CntW   = 4;
    localparam int unsigned CntMax = 15;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] PC_in, Instruction_in, PC, Instruction;
    logic [CntW-1:0] stall_cnt;

    entry_t      q[$];
    int unsigned exp_cnt = 0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W    (32),
        .PC_W      (32),
        .NOP_INSTR (NopInstr),
        .CNT_W     (CntW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .PC_in          (PC_in),
        .Instruction_in (Instruction_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .PC             (PC),
        .Instruction    (Instruction),
        .stall_cnt      (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic cycle(input logic r, input logic fl, input logic fr, input logic iv,
                         input logic [31:0] pc, input logic ordy);
        entry_t e;
        logic   exp_rdy, acc, stall;
        @(negedge clk);
        rst            = r;
        flush          = fl;
        freeze         = fr;
        in_valid       = iv;
        PC_in          = pc;
        Instruction_in = $urandom;
        out_ready      = ordy;
        #1;
        exp_rdy = !r && !fr && (q.size() < 2);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("PC", PC, (q.size() > 0) ? q[0].pc : 32'h0);
        check("Instruction", Instruction, (q.size() > 0) ? q[0].ins : NopInstr);
        check("stall_cnt", 32'(stall_cnt), exp_cnt);
        acc   = iv && exp_rdy;
        stall = ((q.size() > 0) && !ordy) || fr;
        e.valid = 1'b1;
        e.pc    = PC_in;
        e.ins   = Instruction_in;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (stall && exp_cnt < CntMax) exp_cnt++;
            if (fl) begin
                q.delete();
            end else if (!fr) begin
                if ((q.size() > 0) && ordy) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; PC_in = '0; Instruction_in = '0;
        // Reset
        cycle(1, 0, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 1, 32'h0, 1);
        // Streaming
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 32'(i * 4), 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        // Back-pressure
        cycle(0, 0, 0, 1, 32'h10, 0);
        cycle(0, 0, 0, 1, 32'h14, 0);
        cycle(0, 0, 0, 1, 32'h18, 0);
        cycle(0, 0, 0, 1, 32'h18, 1);
        cycle(0, 0, 0, 1, 32'h18, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'h0, 1);
        // Freeze with an entry in main
        cycle(0, 0, 0, 1, 32'h20, 0);
        cycle(0, 0, 1, 1, 32'h24, 1);
        cycle(0, 0, 1, 1, 32'h24, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        // Flush with both slots full and a new entry offered
        cycle(0, 0, 0, 1, 32'h30, 0);
        cycle(0, 0, 0, 1, 32'h34, 0);
        cycle(0, 1, 0, 1, 32'h40, 0);
        cycle(0, 0, 0, 0, 32'h0, 1);
        // Flush during freeze, then reset mid back-pressure
        cycle(0, 0, 0, 1, 32'h50, 0);
        cycle(0, 0, 0, 1, 32'h54, 0);
        cycle(0, 1, 1, 1, 32'h58, 1);
        cycle(0, 0, 0, 1, 32'h60, 0);
        cycle(0, 0, 0, 1, 32'h64, 0);
        cycle(1, 0, 0, 1, 32'h68, 0);
        cycle(0, 0, 0, 0, 32'h0, 0);
        // Counter saturation
        cycle(0, 0, 0, 1, 32'h70, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 32'h0, 0);
        check("stall_sat", 32'(stall_cnt), 32'(CntMax));
        cycle(1, 0, 0, 0, 32'h0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(99) < 2), ($urandom_range(99) < 5),
                  ($urandom_range(99) < 10), ($urandom_range(99) < 70),
                  $urandom, ($urandom_range(99) < 60));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
